// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage load/store unit.
// Issues one data-memory access per EX/MEM entry, stalls upstream until the
// access acknowledges or times out, and registers the MEM/WB fields.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of silently aligning them).
module mem_stage_lsu #(
    parameter int unsigned DM_ADDR_W   = 9,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 reg_write,
    input  logic                 mem_to_reg,
    input  logic [31:0]          alu_result,
    input  logic [31:0]          rd_two,
    input  logic [4:0]           rd,
    input  logic [2:0]           func3,
    input  logic [1:0]           load_size,
    input  logic                 load_signed,
    output logic                 stall,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic [31:0]          dm_wdata,
    output logic [3:0]           dm_be,
    input  logic                 dm_ack,
    input  logic [31:0]          dm_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic                 wb_mem_to_reg,
    output logic [4:0]           wb_rd,
    output logic [31:0]          wb_alu_result,
    output logic [31:0]          wb_mem_data,
    output logic                 misalign,
    output logic                 bus_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic        memop, is_store, misalign_hit, timeout_hit, start;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_c, shifted;
    logic        unused_ok;

    // Decode the entry: op kind, misalign trap, timeout and the stall request.
    // The final timeout cycle drops stall so the aborted entry retires with it.
    always_comb begin
        memop        = mem_read | mem_write;
        is_store     = mem_write;
`ifdef LSU_MISALIGN_TRAP_EN
        if (is_store)
            misalign_hit = (func3[1:0] == 2'b01) ? alu_result[0] :
                           (func3[1:0] == 2'b00) ? 1'b0 : |alu_result[1:0];
        else
            misalign_hit = (load_size == 2'b01) ? alu_result[0] :
                           (load_size == 2'b00) ? 1'b0 : |alu_result[1:0];
        misalign_hit = misalign_hit & in_valid & memop;
`else
        misalign_hit = 1'b0;
`endif
        start        = (state == IDLE) & in_valid & memop & ~misalign_hit;
        timeout_hit  = (state == ACCESS) & ~dm_ack & (cnt == 8'(TIMEOUT_CYC - 1));
        stall        = ~reset & (start | ((state == ACCESS) & ~dm_ack & ~timeout_hit));
        unused_ok    = ^{alu_result[31:DM_ADDR_W+2], func3[2]};
    end

    // Store lane enables / replicated write data and load extraction.
    always_comb begin
        case (func3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << alu_result[1:0];
                wdata_c = {4{rd_two[7:0]}};
            end
            2'b01: begin
                be_c    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{rd_two[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = rd_two;
            end
        endcase
        shifted = dm_rdata >> {alu_result[1:0], 3'b000};
        case (load_size)
            2'b00:   load_c = {{24{load_signed & shifted[7]}}, shifted[7:0]};
            2'b01:   load_c = alu_result[1] ?
                              {{16{load_signed & dm_rdata[31]}}, dm_rdata[31:16]} :
                              {{16{load_signed & dm_rdata[15]}}, dm_rdata[15:0]};
            default: load_c = dm_rdata;
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACCESS;
            ACCESS:  if (dm_ack || timeout_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, access counter and the registered memory request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_be    <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                cnt      <= '0;
                dm_req   <= 1'b1;
                dm_we    <= is_store;
                dm_addr  <= alu_result[DM_ADDR_W+1:2];
                dm_wdata <= wdata_c;
                dm_be    <= is_store ? be_c : 4'b1111;
            end else if (state == ACCESS) begin
                if (dm_ack || timeout_hit) begin
                    dm_req <= 1'b0;
                    dm_we  <= 1'b0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    // MEM/WB register: cleared every cycle unless an entry completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
            if ((state == IDLE && in_valid && (!memop || misalign_hit)) ||
                (state == ACCESS && (dm_ack || timeout_hit))) begin
                wb_valid      <= 1'b1;
                wb_mem_to_reg <= mem_to_reg;
                wb_rd         <= rd;
                wb_alu_result <= alu_result;
                wb_reg_write  <= reg_write & ~misalign_hit & ~timeout_hit;
                misalign      <= (state == IDLE) & misalign_hit;
                bus_err       <= timeout_hit;
                if (state == ACCESS && dm_ack && !is_store)
                    wb_mem_data <= load_c;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (TIMEOUT_CYC overridden to 4).
module tb_mem_stage_lsu;

    localparam int TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset;
    logic        in_valid, mem_read, mem_write, reg_write, mem_to_reg;
    logic [31:0] alu_result, rd_two, dm_rdata, dm_wdata, wb_alu_result, wb_mem_data;
    logic [4:0]  rd, wb_rd;
    logic [2:0]  func3;
    logic [1:0]  load_size;
    logic        load_signed, stall, dm_req, dm_we, dm_ack;
    logic [8:0]  dm_addr;
    logic [3:0]  dm_be;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, misalign, bus_err;

    int n_cmp = 0, n_err = 0;
    logic [31:0] last_mem_data, last_wdata, last_addr;
    logic [3:0]  last_be;
    logic        last_we, last_bus_err, last_misalign, last_rw, last_req;
    int          stall_cnt;

    mem_stage_lsu #(.DM_ADDR_W(9), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_result(alu_result), .rd_two(rd_two), .rd(rd), .func3(func3),
        .load_size(load_size), .load_signed(load_signed), .stall(stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] code);
        return (code == 2'b00) ? 1 : (code == 2'b01) ? 2 : 4;
    endfunction

    // Byte-array view of the returned word: pick n bytes at the aligned base.
    function automatic logic [31:0] load_model(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [1:0] lsz, input logic sgn);
        int n;
        int base;
        longint v;
        n = nbytes(lsz);
        base = (int'(addr % 4) / n) * n;
        v = 0;
        for (int i = 0; i < n; i++)
            v += longint'((rdata >> (8 * (base + i))) & 32'hFF) << (8 * i);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic logic [3:0] be_model(input logic [31:0] addr, input logic [1:0] code);
        int n;
        int base;
        logic [3:0] be;
        n = nbytes(code);
        base = (int'(addr % 4) / n) * n;
        for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + n);
        return be;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [31:0] data, input logic [1:0] code);
        int n;
        logic [31:0] w;
        n = nbytes(code);
        for (int j = 0; j < 4; j++) w[8*j +: 8] = data[8*(j % n) +: 8];
        return w;
    endfunction

    // One EX/MEM entry from presentation to write-back, then one idle cycle.
    task automatic run_op(input logic rd_en, input logic wr_en, input logic rw, input logic m2r,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rdi,
                          input logic [2:0] f3, input logic [1:0] lsz, input logic lsgn,
                          input int ack_dly, input logic [31:0] rdata);
        logic memop, store, trap, tmo_exp;
        logic [1:0] code;
        logic [31:0] exp_addr;
        memop = rd_en | wr_en;
        store = wr_en;
        code = store ? f3[1:0] : lsz;
        trap = TRAP_EN && memop && ((addr % 4) % nbytes(code) != 0);
        exp_addr = (addr >> 2) & 32'h1FF;
        in_valid = 1'b1; mem_read = rd_en; mem_write = wr_en; reg_write = rw;
        mem_to_reg = m2r; alu_result = addr; rd_two = sdata; rd = rdi; func3 = f3;
        load_size = lsz; load_signed = lsgn; dm_ack = 1'b0;
        stall_cnt = 0;
        last_bus_err = 1'b0;
        #3;
        chk("stall_entry", stall, memop && !trap);
        if (stall) stall_cnt++;
        @(posedge clk); #1;
        if (!memop || trap) begin
            last_req = dm_req;
            chk("dm_req_noacc", dm_req, 0);
        end else begin
            last_addr = dm_addr; last_be = dm_be; last_we = dm_we; last_wdata = dm_wdata;
            last_req = dm_req;
            chk("dm_req_on", dm_req, 1);
            chk("dm_we", dm_we, store);
            chk("dm_addr", dm_addr, exp_addr);
            if (store) begin
                chk("dm_be", dm_be, be_model(addr, code));
                chk("dm_wdata", dm_wdata, wdata_model(sdata, code));
            end else if (nbytes(code) == 4) begin
                chk("dm_be_ld", dm_be, 4'b1111);
            end
            for (int c = 0; c < TMO; c++) begin
                if (c == ack_dly) begin dm_ack = 1'b1; dm_rdata = rdata; end
                else dm_rdata = $urandom;
                #3;
                chk("stall_acc", stall, !(c == ack_dly || c == TMO - 1));
                if (stall) stall_cnt++;
                chk("dm_req_hold", dm_req, 1);
                chk("dm_addr_hold", dm_addr, exp_addr);
                @(posedge clk); #1;
                dm_ack = 1'b0;
                if (c == ack_dly || c == TMO - 1) break;
                chk("wb_valid_wait", wb_valid, 0);
            end
            chk("dm_req_off", dm_req, 0);
        end
        tmo_exp = memop && !trap && ack_dly >= TMO;
        last_mem_data = wb_mem_data; last_bus_err = bus_err;
        last_misalign = misalign; last_rw = wb_reg_write;
        chk("wb_valid", wb_valid, 1);
        chk("wb_reg_write", wb_reg_write, rw && !trap && !tmo_exp);
        chk("wb_mem_to_reg", wb_mem_to_reg, m2r);
        chk("wb_rd", wb_rd, rdi);
        chk("wb_alu_result", wb_alu_result, addr);
        chk("wb_mem_data", wb_mem_data,
            (!memop || trap || store || tmo_exp) ? 32'h0 : load_model(rdata, addr, lsz, lsgn));
        chk("misalign", misalign, trap);
        chk("bus_err", bus_err, tmo_exp);
        in_valid = 1'b0;
        dm_ack = 1'($urandom_range(0, 1));
        #3;
        chk("stall_idle", stall, 0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("wb_valid_idle", wb_valid, 0);
        chk("dm_req_idle", dm_req, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
        mem_to_reg = 1'b1; alu_result = 32'h10; rd_two = '0; rd = 5'd3; func3 = 3'b010;
        load_size = 2'b10; load_signed = 1'b0; dm_ack = 1'b1; dm_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_stall", stall, 0);
        chk("rst_dm_req", dm_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_dm_be", dm_be, 0);
        chk("rst_wb_alu", wb_alu_result, 0);
        in_valid = 1'b0; dm_ack = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_wb_valid", wb_valid, 0);

        // lw 0x10, ack in first ACCESS cycle
        run_op(1, 0, 1, 1, 32'h10, 32'h0, 5'd1, 3'b010, 2'b10, 0, 0, 32'hDEADBEEF);
        chk("lw_data", last_mem_data, 32'hDEADBEEF);
        chk("lw_addr", last_addr, 32'd4);
        chk("lw_be", last_be, 4'b1111);
        // lb / lbu at 0x13
        run_op(1, 0, 1, 1, 32'h13, 32'h0, 5'd2, 3'b000, 2'b00, 1, 1, 32'h80FF0000);
        chk("lb_data", last_mem_data, 32'hFFFFFF80);
        run_op(1, 0, 1, 1, 32'h13, 32'h0, 5'd2, 3'b000, 2'b00, 0, 0, 32'h80FF0000);
        chk("lbu_data", last_mem_data, 32'h00000080);
        // sh 0x22, ack in third ACCESS-path cycle
        run_op(0, 1, 0, 0, 32'h22, 32'h1234ABCD, 5'd0, 3'b001, 2'b00, 0, 2, 32'h0);
        chk("sh_we", last_we, 1);
        chk("sh_be", last_be, 4'b1100);
        chk("sh_wdata", last_wdata, 32'hABCDABCD);
        chk("sh_stall_cycles", stall_cnt, 3);
        // lw never acknowledged
        run_op(1, 0, 1, 1, 32'h40, 32'h0, 5'd5, 3'b010, 2'b10, 0, 100, 32'h0);
        chk("tmo_bus_err", last_bus_err, 1);
        chk("tmo_reg_write", last_rw, 0);
        // read+write together behaves as a store
        run_op(1, 1, 1, 1, 32'h48, 32'hCAFEF00D, 5'd6, 3'b010, 2'b10, 0, 1, 32'h55AA55AA);
        chk("rw_store_data", last_mem_data, 0);
        // lw at 0x11: trap or forced alignment
        run_op(1, 0, 1, 1, 32'h11, 32'h0, 5'd7, 3'b010, 2'b10, 0, 0, 32'h01020304);
        if (TRAP_EN) begin
            chk("mis_req", last_req, 0);
            chk("mis_flag", last_misalign, 1);
        end else begin
            chk("mis_addr", last_addr, 32'd4);
            chk("mis_be", last_be, 4'b1111);
        end

        // reset in the middle of an access
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h80;
        load_size = 2'b10; dm_ack = 1'b0;
        @(posedge clk); #1;
        chk("mid_req", dm_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req", dm_req, 0);
        chk("mid_rst_stall", stall, 0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 32'h12345678;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("post_rst_wb", wb_valid, 0);
        chk("post_rst_req", dm_req, 0);
        @(posedge clk); #1;
        chk("post_rst_wb2", wb_valid, 0);

        // randomized entries
        for (int k = 0; k < 60; k++) begin
            int kind;
            logic [2:0] f3r;
            kind = $urandom_range(0, 3);
            f3r = 3'($urandom_range(0, 2));
            run_op(kind == 1 || kind == 3, kind >= 2, 1'($urandom), 1'($urandom), $urandom,
                   $urandom, 5'($urandom), f3r, 2'($urandom), 1'($urandom),
                   $urandom_range(0, 5), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter DM_ADDR_W, default 9: data-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: max ACCESS cycles before abort, range 1..255.
REQ-003 SHALL have port clk  in  1: sole clock, rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1: EX/MEM entry valid.
REQ-006 SHALL have ports mem_read, mem_write, reg_write, mem_to_reg  in  1 each: EX/MEM control bits.
REQ-007 SHALL have ports alu_result  in  32 (address) and rd_two  in  32 (store data).
REQ-008 SHALL have ports rd  in  5; func3  in  3 (store size 000/001/010); load_size  in  2 (00 byte, 01 half, 10/11 word); load_signed  in  1.
REQ-009 SHALL have port stall  out  1: hold EX/MEM entry and all upstream stages.
REQ-010 SHALL have ports dm_req, dm_we  out  1; dm_addr  out  DM_ADDR_W; dm_wdata  out  32; dm_be  out  4; dm_ack  in  1; dm_rdata  in  32.
REQ-011 SHALL have ports wb_valid, wb_reg_write, wb_mem_to_reg  out  1; wb_rd  out  5; wb_alu_result, wb_mem_data  out  32: MEM/WB fields.
REQ-012 SHALL have ports misalign, bus_err  out  1: one-cycle error pulses aligned with wb_valid.

Function
REQ-013 SHALL use states IDLE and ACCESS.
REQ-014 In IDLE with in_valid=1 and no memory op, SHALL register wb_* next edge with wb_mem_data=0; latency 1; stall=0.
REQ-015 In IDLE with in_valid=1 and mem_read or mem_write, SHALL assert stall combinationally and enter ACCESS next edge with dm_req=1.
REQ-016 stall SHALL equal (IDLE & in_valid & memop & !misalign-trap) | (ACCESS & !dm_ack); upstream holds inputs stable while stall=1.
REQ-017 In ACCESS, dm_req, dm_we, dm_addr, dm_wdata and dm_be SHALL be registered and stable until the dm_ack cycle.
REQ-018 On dm_ack=1 in ACCESS, SHALL return to IDLE and assert wb_valid next edge with load data; dm_req low in that next cycle.
REQ-019 Minimum memory-op latency SHALL be 2 cycles (entry to wb_valid with ack in first ACCESS cycle).
REQ-020 dm_addr SHALL be alu_result[DM_ADDR_W+1:2].
REQ-021 Loads: byte lane alu_result[1:0], half selected by alu_result[1]; sign-extend if load_signed, else zero-extend; word unchanged.
REQ-022 Stores: sb be=0001<<addr[1:0], wdata=4 copies of rd_two[7:0]; sh be=0011 or 1100 by addr[1], wdata=2 copies of rd_two[15:0]; sw be=1111.
REQ-023 mem_read and mem_write both 1 SHALL be treated as store; wb_mem_data=0.
REQ-024 8-bit ACCESS counter SHALL clear on entry; reaching TIMEOUT_CYC without ack SHALL abort: IDLE, wb_valid=1, wb_reg_write=0, bus_err=1 for one cycle.
REQ-025 dm_ack in IDLE SHALL be ignored.
REQ-026 wb_valid SHALL be 0 in every cycle not following a completion.

Reset
REQ-027 reset SHALL force IDLE, counter 0, and all outputs 0 (dm_req drops asynchronously).
REQ-028 reset mid-ACCESS SHALL abandon the access without wb_valid; a later dm_ack SHALL be ignored.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip memory, give wb_valid next edge with wb_reg_write=0, misalign=1, stall=0.
REQ-030 Macro LSU_MISALIGN_TRAP_EN undefined: low address bits beyond access size SHALL be ignored (forced aligned) and misalign tied to 0.

Verification
REQ-031 lw addr 0x10, ack in first ACCESS cycle, dm_rdata=0xDEADBEEF -> dm_addr=4, be=1111, wb_valid 2 cycles after entry, wb_mem_data=0xDEADBEEF.
REQ-032 lb signed addr 0x13, dm_rdata=0x80FF0000 -> wb_mem_data=0xFFFFFF80; lbu same -> 0x00000080.
REQ-033 sh addr 0x22, rd_two=0x1234ABCD, ack after 3 cycles -> dm_we=1, be=1100, wdata=0xABCDABCD, stall high 3 cycles.
REQ-034 TIMEOUT_CYC=4, lw never acked -> after 4 ACCESS cycles bus_err=1, wb_reg_write=0, stall low.
REQ-035 reset asserted mid-ACCESS, dm_ack 1 cycle after release -> dm_req=0 immediately, no wb_valid.
REQ-036 With LSU_MISALIGN_TRAP_EN, lw addr 0x11 -> dm_req stays 0, misalign=1 next cycle; without it, dm_addr=4, be=1111.
